// File: rtl/hashcore_pkg.sv
// rtl/hashcore_pkg.sv - shared types for the hashcore work/result scheduler
package hashcore_pkg;

    localparam int JOB_W   = 4;
    localparam int NONCE_W = 32;
    localparam int CORE_W  = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        SETTLE = 2'd2,
        RUN    = 2'd3
    } state_t;

    typedef struct packed {
        logic [NONCE_W-1:0] nonce;
        logic [CORE_W-1:0]  core;
        logic [JOB_W-1:0]   job;
    } result_t;

endpackage

// File: rtl/sched_result_fifo.sv
// rtl/sched_result_fifo.sv - first-word-fall-through FIFO of golden-nonce results
module sched_result_fifo
    import hashcore_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic    clk,
    input  logic    rst_n,
    input  logic    push_i,
    input  result_t din_i,
    output logic    full_o,
    input  logic    pop_i,
    output logic    empty_o,
    output result_t dout_o
);

    localparam int AW = $clog2(DEPTH);

    result_t       mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q;
    logic          do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign do_pop  = pop_i && !empty_o;
    // A push into a full FIFO is legal when the head leaves in the same cycle.
    assign do_push = push_i && (!full_o || do_pop);
    assign dout_o  = empty_o ? '0 : mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + 1'b1;
            end else if (do_pop && !do_push) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

endmodule

// File: rtl/hashcore_sched.sv
// rtl/hashcore_sched.sv - work broadcast serialiser and golden-nonce result arbiter
module hashcore_sched
    import hashcore_pkg::*;
#(
    parameter int NCORES        = 3,
    parameter int WORK_BITS     = 352,
    parameter int SETTLE_CYCLES = 66,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic                    hash_clk,
    input  logic                    reset_n,
    input  logic [WORK_BITS-1:0]    work_data,
    input  logic                    work_valid,
    output logic                    work_ready,
    output logic                    core_din,
    output logic                    core_shift,
    output logic [3*NCORES-1:0]     core_nonce_msb,
    input  logic [NCORES-1:0]       gn_match,
    input  logic [32*NCORES-1:0]    gn_nonce,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [31:0]             res_nonce,
    output logic [1:0]              res_core,
    output logic [3:0]              res_job,
    output logic [3:0]              job_id,
    output logic                    busy,
    output logic                    overflow
);

    localparam int BIT_W = $clog2(WORK_BITS);
    localparam int SET_W = $clog2(SETTLE_CYCLES + 1);

    state_t               state_q;
    logic [WORK_BITS-1:0] shreg_q;
    logic [BIT_W-1:0]     bitcnt_q;
    logic [SET_W-1:0]     settle_q;
    logic                 core_din_q, core_shift_q;
    logic [JOB_W-1:0]     job_q;
    logic                 overflow_q;

    logic [NCORES-1:0]    pend_v_q;
    logic [NONCE_W-1:0]   pend_nonce_q [NCORES];
    logic [JOB_W-1:0]     pend_job_q   [NCORES];
    logic [CORE_W-1:0]    last_q;

    logic                 grant_v;
    logic [CORE_W-1:0]    grant_idx;
    logic                 fifo_full, fifo_empty, pop, push;
    result_t              push_data, head;

    genvar g;
    generate
        for (g = 0; g < NCORES; g++) begin : g_msb
            assign core_nonce_msb[3*g +: 3] = 3'(g);
        end
    endgenerate

    assign work_ready = (state_q == IDLE) || (state_q == RUN);
    assign core_din   = core_din_q;
    assign core_shift = core_shift_q;
    assign job_id     = job_q;
    assign busy       = (state_q != IDLE);
    assign overflow   = overflow_q;

    // core_din is presented one register stage ahead of the shift register so it lines up with core_shift.
    always_ff @(posedge hash_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            shreg_q      <= '0;
            bitcnt_q     <= '0;
            settle_q     <= '0;
            core_din_q   <= 1'b0;
            core_shift_q <= 1'b0;
            job_q        <= '0;
        end else begin
            case (state_q)
                IDLE, RUN: begin
                    if (work_valid) begin
                        shreg_q      <= work_data << 1;
                        core_din_q   <= work_data[WORK_BITS-1];
                        core_shift_q <= 1'b1;
                        bitcnt_q     <= '0;
                        job_q        <= job_q + 1'b1;
                        state_q      <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (bitcnt_q == BIT_W'(WORK_BITS - 1)) begin
                        core_shift_q <= 1'b0;
                        core_din_q   <= 1'b0;
                        settle_q     <= SET_W'(SETTLE_CYCLES - 1);
                        state_q      <= SETTLE;
                    end else begin
                        bitcnt_q   <= bitcnt_q + 1'b1;
                        core_din_q <= shreg_q[WORK_BITS-1];
                        shreg_q    <= shreg_q << 1;
                    end
                end
                SETTLE: begin
                    if (settle_q == '0) begin
                        state_q <= RUN;
                    end else begin
                        settle_q <= settle_q - 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Round-robin search starts at the core after the last one granted.
    always_comb begin
        int idx;
        grant_v   = 1'b0;
        grant_idx = '0;
        idx       = 0;
        for (int k = 1; k <= NCORES; k++) begin
            idx = int'(last_q) + k;
            if (idx >= NCORES) begin
                idx = idx - NCORES;
            end
            if (!grant_v && pend_v_q[CORE_W'(idx)]) begin
                grant_v   = 1'b1;
                grant_idx = CORE_W'(idx);
            end
        end
    end

    assign pop       = res_valid && res_ready;
    assign push      = grant_v && (!fifo_full || pop);
    assign push_data = '{nonce: pend_nonce_q[grant_idx], core: grant_idx, job: pend_job_q[grant_idx]};

    always_ff @(posedge hash_clk or negedge reset_n) begin
        if (!reset_n) begin
            pend_v_q   <= '0;
            last_q     <= CORE_W'(NCORES - 1);
            overflow_q <= 1'b0;
            for (int i = 0; i < NCORES; i++) begin
                pend_nonce_q[i] <= '0;
                pend_job_q[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < NCORES; i++) begin
                if ((state_q == RUN) && gn_match[i]) begin
                    if (!pend_v_q[i] || (push && grant_idx == CORE_W'(i))) begin
                        pend_v_q[i]     <= 1'b1;
                        pend_nonce_q[i] <= gn_nonce[32*i +: 32];
                        pend_job_q[i]   <= job_q;
                    end else begin
                        overflow_q <= 1'b1;
                    end
                end else if (push && grant_idx == CORE_W'(i)) begin
                    pend_v_q[i] <= 1'b0;
                end
            end
            if (push) begin
                last_q <= grant_idx;
            end
        end
    end

    sched_result_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (hash_clk),
        .rst_n   (reset_n),
        .push_i  (push),
        .din_i   (push_data),
        .full_o  (fifo_full),
        .pop_i   (pop),
        .empty_o (fifo_empty),
        .dout_o  (head)
    );

    assign res_valid = !fifo_empty;
    assign res_nonce = head.nonce;
    assign res_core  = head.core;
    assign res_job   = head.job;

endmodule

// File: tb/tb_hashcore_sched.sv
// tb/tb_hashcore_sched.sv - directed self-checking bench for hashcore_sched
module tb_hashcore_sched;

    logic         hash_clk;
    logic         reset_n;
    logic [351:0] work_data;
    logic         work_valid;
    logic         work_ready;
    logic         core_din;
    logic         core_shift;
    logic [8:0]   core_nonce_msb;
    logic [2:0]   gn_match;
    logic [95:0]  gn_nonce;
    logic         res_valid;
    logic         res_ready;
    logic [31:0]  res_nonce;
    logic [1:0]   res_core;
    logic [3:0]   res_job;
    logic [3:0]   job_id;
    logic         busy;
    logic         overflow;

    int checks;
    int failures;
    logic [351:0] wd;

    hashcore_sched #(
        .NCORES        (3),
        .WORK_BITS     (352),
        .SETTLE_CYCLES (66),
        .FIFO_DEPTH    (4)
    ) dut (
        .hash_clk       (hash_clk),
        .reset_n        (reset_n),
        .work_data      (work_data),
        .work_valid     (work_valid),
        .work_ready     (work_ready),
        .core_din       (core_din),
        .core_shift     (core_shift),
        .core_nonce_msb (core_nonce_msb),
        .gn_match       (gn_match),
        .gn_nonce       (gn_nonce),
        .res_valid      (res_valid),
        .res_ready      (res_ready),
        .res_nonce      (res_nonce),
        .res_core       (res_core),
        .res_job        (res_job),
        .job_id         (job_id),
        .busy           (busy),
        .overflow       (overflow)
    );

    initial hash_clk = 1'b0;
    always #5 hash_clk = ~hash_clk;

    task automatic tick();
        @(posedge hash_clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n    = 1'b0;
        work_data  = '0;
        work_valid = 1'b0;
        gn_match   = '0;
        gn_nonce   = '0;
        res_ready  = 1'b0;
        tick();
        tick();
        checks++;
        if (core_shift !== 1'b0 || core_din !== 1'b0) begin
            failures++;
            $display("FAIL reset_core_bus got shift=%b din=%b exp 0 0", core_shift, core_din);
        end
        checks++;
        if (job_id !== 4'd0 || busy !== 1'b0 || overflow !== 1'b0) begin
            failures++;
            $display("FAIL reset_status got job=%0d busy=%b ovf=%b exp 0 0 0", job_id, busy, overflow);
        end
        checks++;
        if (res_valid !== 1'b0 || res_nonce !== 32'd0 || res_core !== 2'd0 || res_job !== 4'd0) begin
            failures++;
            $display("FAIL reset_result got v=%b n=%h c=%0d j=%0d exp all zero", res_valid, res_nonce, res_core, res_job);
        end
        checks++;
        if (core_nonce_msb !== 9'b010_001_000) begin
            failures++;
            $display("FAIL nonce_msb got=%b exp=%b", core_nonce_msb, 9'b010_001_000);
        end
        checks++;
        if (work_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_work_ready got=%b exp=1", work_ready);
        end
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_load();
        wd         = {11{32'h5A0F_C3A5}};
        work_data  = wd;
        work_valid = 1'b1;
        tick();
        work_valid = 1'b0;
        checks++;
        if (job_id !== 4'd1 || work_ready !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL load_status got job=%0d ready=%b busy=%b exp 1 0 1", job_id, work_ready, busy);
        end
        for (int i = 0; i < 352; i++) begin
            checks++;
            if (core_shift !== 1'b1 || core_din !== wd[351-i]) begin
                failures++;
                $display("FAIL shift_bit%0d got shift=%b din=%b exp 1 %b", i, core_shift, core_din, wd[351-i]);
            end
            tick();
        end
        checks++;
        if (core_shift !== 1'b0 || work_ready !== 1'b0) begin
            failures++;
            $display("FAIL shift_end got shift=%b ready=%b exp 0 0", core_shift, work_ready);
        end
    endtask

    task automatic test_stale_mask();
        int n;
        gn_nonce = {32'h0, 32'h0, 32'h1234_5678};
        gn_match = 3'b001;
        tick();
        gn_match = 3'b000;
        n = 1;
        while (work_ready !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        checks++;
        if (n != 66) begin
            failures++;
            $display("FAIL settle_len got=%0d exp=66", n);
        end
        checks++;
        if (res_valid !== 1'b0 || overflow !== 1'b0) begin
            failures++;
            $display("FAIL stale_mask got v=%b ovf=%b exp 0 0", res_valid, overflow);
        end
        gn_match = 3'b001;
        tick();
        gn_match = 3'b000;
        checks++;
        if (res_valid !== 1'b0) begin
            failures++;
            $display("FAIL run_latency_t1 got v=%b exp 0", res_valid);
        end
        tick();
        checks++;
        if (res_valid !== 1'b1 || res_nonce !== 32'h1234_5678 || res_core !== 2'd0 || res_job !== 4'd1) begin
            failures++;
            $display("FAIL run_match got v=%b n=%h c=%0d j=%0d exp 1 12345678 0 1", res_valid, res_nonce, res_core, res_job);
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        checks++;
        if (res_valid !== 1'b0) begin
            failures++;
            $display("FAIL run_pop got v=%b exp 0", res_valid);
        end
    endtask

    task automatic test_simultaneous();
        logic [31:0] exp_n [3];
        logic [1:0]  exp_c [3];
        // last grant was core 0, so service order is 1, 2, 0
        exp_n[0] = 32'h200; exp_c[0] = 2'd1;
        exp_n[1] = 32'h300; exp_c[1] = 2'd2;
        exp_n[2] = 32'h100; exp_c[2] = 2'd0;
        res_ready = 1'b1;
        gn_nonce  = {32'h300, 32'h200, 32'h100};
        gn_match  = 3'b111;
        tick();
        gn_match = 3'b000;
        tick();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (res_valid !== 1'b1 || res_nonce !== exp_n[i] || res_core !== exp_c[i]) begin
                failures++;
                $display("FAIL simul_%0d got v=%b n=%h c=%0d exp 1 %h %0d", i, res_valid, res_nonce, res_core, exp_n[i], exp_c[i]);
            end
            tick();
        end
        checks++;
        if (res_valid !== 1'b0 || overflow !== 1'b0) begin
            failures++;
            $display("FAIL simul_end got v=%b ovf=%b exp 0 0", res_valid, overflow);
        end
        res_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        logic [31:0] exp_n [5];
        logic [1:0]  exp_c [5];
        exp_n[0] = 32'hB1; exp_c[0] = 2'd1;
        exp_n[1] = 32'hB2; exp_c[1] = 2'd2;
        exp_n[2] = 32'hB0; exp_c[2] = 2'd0;
        exp_n[3] = 32'hB3; exp_c[3] = 2'd2;
        exp_n[4] = 32'hC1; exp_c[4] = 2'd1;
        res_ready = 1'b0;
        gn_nonce  = {32'hB2, 32'hB1, 32'hB0};
        gn_match  = 3'b111;
        tick();
        gn_match = 3'b000;
        tick();
        tick();
        tick();
        gn_nonce = {32'hB3, 32'h0, 32'h0};
        gn_match = 3'b100;
        tick();
        gn_match = 3'b000;
        tick();
        gn_nonce = {32'h0, 32'hC1, 32'h0};
        gn_match = 3'b010;
        tick();
        gn_match = 3'b000;
        checks++;
        if (overflow !== 1'b0 || res_nonce !== 32'hB1) begin
            failures++;
            $display("FAIL bp_first_hold got ovf=%b n=%h exp 0 b1", overflow, res_nonce);
        end
        gn_nonce = {32'h0, 32'hC2, 32'h0};
        gn_match = 3'b010;
        tick();
        gn_match = 3'b000;
        checks++;
        if (overflow !== 1'b1) begin
            failures++;
            $display("FAIL bp_overflow got=%b exp=1", overflow);
        end
        res_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (res_valid !== 1'b1 || res_nonce !== exp_n[i] || res_core !== exp_c[i] || res_job !== 4'd1) begin
                failures++;
                $display("FAIL bp_drain_%0d got v=%b n=%h c=%0d j=%0d exp 1 %h %0d 1", i, res_valid, res_nonce, res_core, res_job, exp_n[i], exp_c[i]);
            end
            tick();
        end
        checks++;
        if (res_valid !== 1'b0) begin
            failures++;
            $display("FAIL bp_empty got v=%b exp 0", res_valid);
        end
        res_ready = 1'b0;
    endtask

    task automatic test_abort();
        gn_nonce = {32'h0, 32'h0, 32'hABCD_0001};
        gn_match = 3'b001;
        tick();
        gn_match   = 3'b000;
        work_data  = ~wd;
        work_valid = 1'b1;
        tick();
        work_valid = 1'b0;
        checks++;
        if (job_id !== 4'd2 || core_shift !== 1'b1 || work_ready !== 1'b0 || core_din !== ~wd[351]) begin
            failures++;
            $display("FAIL abort_load got job=%0d shift=%b ready=%b din=%b exp 2 1 0 %b", job_id, core_shift, work_ready, core_din, ~wd[351]);
        end
        checks++;
        if (res_valid !== 1'b1 || res_nonce !== 32'hABCD_0001 || res_core !== 2'd0 || res_job !== 4'd1) begin
            failures++;
            $display("FAIL abort_result got v=%b n=%h c=%0d j=%0d exp 1 abcd0001 0 1", res_valid, res_nonce, res_core, res_job);
        end
        checks++;
        if (overflow !== 1'b1) begin
            failures++;
            $display("FAIL overflow_sticky got=%b exp=1", overflow);
        end
    endtask

    task automatic test_async_reset();
        tick();
        tick();
        tick();
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (core_shift !== 1'b0 || res_valid !== 1'b0 || job_id !== 4'd0) begin
            failures++;
            $display("FAIL async_reset got shift=%b v=%b job=%0d exp 0 0 0", core_shift, res_valid, job_id);
        end
        checks++;
        if (busy !== 1'b0 || work_ready !== 1'b1 || overflow !== 1'b0) begin
            failures++;
            $display("FAIL async_reset_state got busy=%b ready=%b ovf=%b exp 0 1 0", busy, work_ready, overflow);
        end
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_load();
        test_stale_mask();
        test_simultaneous();
        test_backpressure();
        test_abort();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hashcore_sched.md
Name: hashcore_sched

Overview:
- Work/result scheduler for a bank of NCORES hashcore instances sharing one work broadcast.
- Serialises each accepted work packet onto the cores' din/shift bit-serial load bus and assigns each core its static nonce_msb partition.
- Masks stale matches while the core pipelines refill after a load.
- Collects one-cycle golden-nonce strobes from all cores and round-robin arbitrates them into a small FIFO drained by the serial TX path over valid/ready.

Parameters:
- NCORES, 3, number of hashcores (1..4).
- WORK_BITS, 352, bits shifted into each core per work packet.
- SETTLE_CYCLES, 66, cycles after shift falls during which core matches are discarded (pipeline refill plus 2 margin).
- FIFO_DEPTH, 4, result FIFO entries (power of 2).

Ports:
- hash_clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- work_data  in  WORK_BITS  work packet, MSB shifted first
- work_valid  in  1  work offered
- work_ready  out  1  work accepted when valid&ready
- core_din  out  1  broadcast serial data to cores
- core_shift  out  1  broadcast shift strobe to cores
- core_nonce_msb  out  3*NCORES  core i slice = i (constant)
- gn_match  in  NCORES  per-core one-cycle match strobe
- gn_nonce  in  32*NCORES  per-core golden nonce, valid with strobe
- res_valid  out  1  result available
- res_ready  in  1  TX consumes result
- res_nonce  out  32  result nonce
- res_core  out  2  originating core index
- res_job  out  4  job id of work that produced result
- job_id  out  4  id of current work
- busy  out  1  state != IDLE
- overflow  out  1  sticky: a match was dropped

Behaviour:
- Reset (async, reset_n=0) values:
  - state=IDLE; core_din=0, core_shift=0; job_id=0; overflow=0; busy=0.
  - FIFO empty (res_valid=0, res_nonce=0, res_core=0, res_job=0); pending registers empty.
- States:
  - IDLE: work_ready=1. On accept: latch work_data into shift register, job_id<=job_id+1 (wraps 15->0), go to SHIFT.
  - SHIFT: work_ready=0. core_shift=1 for exactly WORK_BITS consecutive cycles. core_din = shift-register MSB, registered, aligned with core_shift; shift left each cycle. Bit counter reaches WORK_BITS-1 -> SETTLE next cycle, core_shift=0.
  - SETTLE: work_ready=0. Down-counter from SETTLE_CYCLES; reaching 0 -> RUN.
  - RUN: work_ready=1. Matches are enabled. New work accept -> SHIFT immediately (abort current job, new job_id). work is never dropped; it waits in IDLE/RUN until accepted.
- Match capture:
  - Per-core 1-deep pending register {nonce, job}.
  - Enabled only in RUN. In SHIFT/SETTLE, strobes are ignored, with no overflow.
  - In RUN, a strobe on core i with pending[i] empty captures gn_nonce slice i and current job_id.
  - A strobe with pending[i] still full drops the new match and sets overflow=1. overflow is sticky until reset.
- Arbitration:
  - Each cycle with FIFO not full, push one pending entry chosen round-robin starting after the last granted core.
  - A pending register freed by a push may capture a same-cycle strobe (no drop).
  - All NCORES strobing in one cycle are all captured and drained over NCORES cycles.
- FIFO:
  - First-word-fall-through.
  - res_valid = not empty; pop on res_valid&res_ready.
  - Push and pop in the same cycle when full is allowed (count unchanged).
  - Pending entries already captured stay valid across a new work load; res_job identifies them.
- Latency: strobe at cycle t -> pending at t+1 -> FIFO/res_valid at t+2 if FIFO empty and no contention.
- core_nonce_msb is combinational constant, independent of reset.

Decomposition:
- Shared package hashcore_pkg:
  - state enum {IDLE, SHIFT, SETTLE, RUN};
  - JOB_W=4, NONCE_W=32, CORE_W=2;
  - result struct {nonce, core, job}.
- Sub-module sched_result_fifo: parameterised synchronous FWFT FIFO over the result struct. Arbiter and FSM stay in the top module.

Test Plan:
- Load: work_data=0x...A5 (WORK_BITS), work_valid pulse in IDLE -> core_shift high exactly 352 cycles, core_din sequence equals work_data MSB-first, job_id=1, RUN entered 66 cycles after core_shift falls.
- Stale mask: gn_match[0]=1, nonce 0x12345678, during SETTLE -> no res_valid, overflow=0. Same strobe in RUN -> res_valid 2 cycles later, res_nonce=0x12345678, res_core=0, res_job=1.
- Simultaneous: all 3 cores strobe same cycle in RUN (nonces 0x100, 0x200, 0x300), res_ready=1 -> three results on consecutive cycles in round-robin order, overflow=0.
- Backpressure: res_ready=0; 4 results fill FIFO, then core 1 strobes twice -> first held in pending, second sets overflow=1; raising res_ready drains 5 results.
- Abort: new work accepted in RUN with a result pending -> SHIFT restarts, job_id=2, pending result emerges with res_job=1.
- Async reset asserted mid-SHIFT -> core_shift=0, res_valid=0, job_id=0, state IDLE immediately without a clock edge.
